register_file_32x32: RTL and testbench
======================================

// Module: register_file_32x32
// PURPOSE
//  32-entry x 32-bit general-purpose register file for the datapath; consumes the 5-bit write
//  selector and internally decodes it to a fully specified one-hot write-enable vector.
//  Two registered read ports feed the ALU operand stage. A sequenced clear engine zeroes
//  the array one entry per cycle on request.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of all data ports
//  ADDR_WIDTH  5   register address width; NUM_REGS = 2**ADDR_WIDTH
//  ZERO_REG    1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk_i        in   1           single clock, all state on rising edge
//  rst_n_i      in   1           asynchronous, active-low reset
//  wr_en_i      in   1           write request
//  wr_addr_i    in   ADDR_WIDTH  write selector
//  wr_data_i    in   DATA_WIDTH  write data
//  rd_en_i      in   1           read request, both ports
//  rd_addr_a_i  in   ADDR_WIDTH  port A read address
//  rd_addr_b_i  in   ADDR_WIDTH  port B read address
//  rd_data_a_o  out  DATA_WIDTH  port A read data, registered
//  rd_data_b_o  out  DATA_WIDTH  port B read data, registered
//  rd_valid_o   out  1           read data valid, registered
//  clear_i      in   1           start clear sequence (sampled in IDLE only)
//  busy_o       out  1           clear in progress; writes/reads ignored
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all registers 0, rd_data_a_o/rd_data_b_o=0, rd_valid_o=0,
//    busy_o=0, state IDLE, clear counter 0. Reset mid-clear aborts to IDLE with array zeroed.
//  - Write decode: combinational one-hot vector, every bit assigned every evaluation; all 0
//    when wr_en_i=0, busy_o=1, or (ZERO_REG=1 and wr_addr_i=0). Register updates at next edge.
//  - Read latency 1: rd_en_i=1 at edge N (state IDLE) -> rd_data_*_o and rd_valid_o=1 after N.
//    rd_en_i=0 -> rd_valid_o=0 next cycle, rd_data_*_o hold previous values.
//  - Bypass: same-cycle wr_en_i=1 with wr_addr_i==rd_addr_x_i returns wr_data_i on that port
//    (new data), except ZERO_REG=1 and address 0, which returns 0.
//  - ZERO_REG=1: address 0 always reads 0 regardless of writes or bypass.
//  - FSM: IDLE --clear_i=1--> CLEAR; CLEAR --counter==NUM_REGS-1--> IDLE.
//    CLEAR: each cycle zeroes register[counter], counter increments; exactly NUM_REGS cycles.
//    busy_o registered: 1 from the edge entering CLEAR to the edge leaving it.
//    In CLEAR: wr_en_i and rd_en_i ignored, rd_valid_o=0, clear_i ignored (no restart).
//  - clear_i and wr_en_i same cycle in IDLE: clear wins, write dropped.
//  - clear_i and rd_en_i same cycle in IDLE: clear wins, rd_valid_o=0 next cycle.
//  - Counter is ADDR_WIDTH bits; wrap to 0 on exit, no overflow state.
// TESTING
//  1. Reset, then rd_en_i=1 addr A=5,B=31 -> next cycle rd_valid_o=1, both data 0.
//  2. Write reg 7=0xDEADBEEF, then read A=7 -> 0xDEADBEEF one cycle after rd_en_i.
//  3. Same cycle write reg 9=0x12345678 and read A=9,B=9 -> both ports 0x12345678 (bypass).
//  4. ZERO_REG=1: write reg 0=0xFFFFFFFF, read A=0 -> 0; same-cycle bypass on addr 0 -> 0.
//  5. Fill all 32 regs with index+1, pulse clear_i -> busy_o high exactly 32 cycles, writes/
//     reads during clear ignored (rd_valid_o=0); afterwards all reads return 0.
//  6. Assert rst_n_i low at clear cycle 10 -> outputs 0 immediately, busy_o=0, all regs read 0.

Source files
------------

// File: rtl/register_file_32x32_if.sv
// Register file access bus: write port, dual read ports and clear control.
// Modports: master drives requests, slave (the register file) returns data/busy.
interface register_file_32x32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_a_i;
    logic [ADDR_WIDTH-1:0] rd_addr_b_i;
    logic [DATA_WIDTH-1:0] rd_data_a_o;
    logic [DATA_WIDTH-1:0] rd_data_b_o;
    logic                  rd_valid_o;
    logic                  clear_i;
    logic                  busy_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i,
        output rd_en_i, rd_addr_a_i, rd_addr_b_i,
        output clear_i,
        input  rd_data_a_o, rd_data_b_o, rd_valid_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i,
        input  rd_en_i, rd_addr_a_i, rd_addr_b_i,
        input  clear_i,
        output rd_data_a_o, rd_data_b_o, rd_valid_o, busy_o
    );
endinterface

// File: rtl/register_file_32x32.sv
// 32x32 register file: one-hot write decode, two registered read ports with
// write bypass, and a one-entry-per-cycle clear engine. Ports: clk_i, rst_n_i, bus (slave).
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    register_file_32x32_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  idle;
    logic                  clear_go;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] nxt_a;
    logic [DATA_WIDTH-1:0] nxt_b;

    assign idle     = (state == IDLE);
    assign clear_go = idle && bus.clear_i;
    // A clear request in IDLE suppresses any same-cycle read or write.
    assign rd_go    = idle && bus.rd_en_i && !bus.clear_i;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = idle && bus.wr_en_i && !bus.clear_i
                        && (bus.wr_addr_i == ADDR_WIDTH'(i))
                        && !((ZERO_REG != 0) && (i == 0));
        end
    end

    // Read value with bypass of a same-cycle write; hard zero on reg 0.
    function automatic logic [DATA_WIDTH-1:0] rd_val(
        input logic [ADDR_WIDTH-1:0] addr
    );
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        if (bus.wr_en_i && (bus.wr_addr_i == addr))
            return bus.wr_data_i;
        return regs[addr];
    endfunction

    always_comb begin
        nxt_a = rd_val(bus.rd_addr_a_i);
        nxt_b = rd_val(bus.rd_addr_b_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            unique case (1'b1)
                (state == CLEAR): begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST)
                        state <= IDLE;
                end
                clear_go: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_sel[i])
                    regs[i] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.rd_data_a_o <= '0;
            bus.rd_data_b_o <= '0;
            bus.rd_valid_o  <= 1'b0;
        end else begin
            bus.rd_valid_o <= rd_go;
            if (rd_go) begin
                bus.rd_data_a_o <= nxt_a;
                bus.rd_data_b_o <= nxt_b;
            end
        end
    end

    assign bus.busy_o = (state == CLEAR);
endmodule

// File: tb/tb_register_file_32x32.sv
// Randomized and directed bench for register_file_32x32 against an
// array-based reference model.
module tb_register_file_32x32;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] mdl [32];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_v;
    int          clr_left;
    int          clr_idx;
    int          busy_cycles;

    register_file_32x32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file_32x32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG  (1)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.wr_en_i && bus.wr_addr_i == a) return bus.wr_data_i;
        return mdl[a];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        exp_a = 0;
        exp_b = 0;
        exp_v = 0;
        clr_left = 0;
        clr_idx = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, 32'(bus.rd_valid_o), 32'(exp_v));
        check({tag, "_busy"}, 32'(bus.busy_o), 32'(clr_left > 0));
        check({tag, "_a"}, bus.rd_data_a_o, exp_a);
        check({tag, "_b"}, bus.rd_data_b_o, exp_b);
    endtask

    // One clock: apply inputs, update model per behavioural rules, compare.
    task automatic step(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic re,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic clr, input string tag);
        @(negedge clk);
        bus.wr_en_i = we;
        bus.wr_addr_i = wa;
        bus.wr_data_i = wd;
        bus.rd_en_i = re;
        bus.rd_addr_a_i = ra;
        bus.rd_addr_b_i = rb;
        bus.clear_i = clr;
        @(posedge clk);
        if (clr_left > 0) begin
            mdl[clr_idx] = 0;
            clr_idx++;
            clr_left--;
            exp_v = 0;
        end else if (clr) begin
            clr_left = 32;
            clr_idx = 0;
            exp_v = 0;
        end else begin
            if (re) begin
                exp_a = mread(ra);
                exp_b = mread(rb);
            end
            exp_v = re;
            if (we && wa != 0) mdl[wa] = wd;
        end
        #1;
        if (bus.busy_o) busy_cycles++;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        busy_cycles = 0;
        mreset();
        rst_n = 1'b0;
        bus.wr_en_i = 0;
        bus.wr_addr_i = 0;
        bus.wr_data_i = 0;
        bus.rd_en_i = 0;
        bus.rd_addr_a_i = 0;
        bus.rd_addr_b_i = 0;
        bus.clear_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0, 1, 5, 31, 0, "t1_read0");
        step(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, "t2_wr");
        step(0, 0, 0, 1, 7, 0, 0, "t2_rd");
        check("t2_data", bus.rd_data_a_o, 32'hDEADBEEF);
        step(1, 9, 32'h12345678, 1, 9, 9, 0, "t3_byp");
        check("t3_byp_b", bus.rd_data_b_o, 32'h12345678);
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, "t4_wr0");
        step(0, 0, 0, 1, 0, 7, 0, "t4_rd0");
        step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "t4_byp0");
        check("t4_zero", bus.rd_data_a_o, 32'h0);
        step(0, 0, 0, 0, 3, 3, 0, "hold");

        for (int i = 0; i < 32; i++)
            step(1, 5'(i), 32'(i + 1), 0, 0, 0, 0, "t5_fill");
        busy_cycles = 0;
        step(1, 4, 32'hAAAA5555, 1, 4, 5, 1, "t5_clr_go");
        for (int i = 0; i < 32; i++)
            step(1, 5'($urandom), $urandom, 1, 5'(i), 5'(i), $urandom_range(0, 1) == 1,
                 "t5_clr");
        check("t5_busy_len", 32'(busy_cycles), 32'd32);
        for (int i = 0; i < 32; i += 2)
            step(0, 0, 0, 1, 5'(i), 5'(i + 1), 0, "t5_post");

        for (int i = 0; i < 32; i++)
            step(1, 5'(i), 32'hC000_0000 + 32'(i), 0, 0, 0, 0, "t6_fill");
        step(0, 0, 0, 0, 0, 0, 1, "t6_clr_go");
        for (int i = 0; i < 10; i++) idle_step("t6_clr");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mreset();
        check_all("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i += 2)
            step(0, 0, 0, 1, 5'(i), 5'(i + 1), 0, "t6_post");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom);
            step($urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                 $urandom_range(0, 49) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
